// File: rtl/apb_ram_bridge.sv
// rtl/apb_ram_bridge.sv - APB slave to single-port RAM request/ready bridge
//
// Purpose:
//   Converts APB transfers into single RAM requests. A transfer is latched in
//   the setup phase. It is issued to the RAM until ram_ready is seen. Read
//   data is captured one cycle after acceptance, and pready is returned one
//   cycle later. A RAM that never answers is reported with pslverr after
//   TIMEOUT cycles.
//
// Configuration:
//   APB_RAM_ADDR_CHECK_EN - when defined, a misaligned paddr or a nonzero
//   paddr[ADDR_WIDTH-1:ADDR_WIDTH-2] is a decode error. A decode error is
//   answered with pready/pslverr and the RAM is not accessed.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata, pstrb  APB address, write data, byte strobes
//   prdata                APB read data (registered)
//   pready, pslverr       APB completion / error (registered)
//   ram_enable, ram_we    RAM request and direction (registered)
//   ram_addr, ram_din     RAM address and write data (registered)
//   ram_strb              RAM byte strobes, zero for reads (registered)
//   ram_ready             RAM accepts the request this cycle
//   ram_dout              RAM read data, valid the cycle after an accepted read

module apb_ram_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    ram_enable,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [DATA_WIDTH/8-1:0] ram_strb,
  input  logic                    ram_ready,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;
  logic                    r_ram_enable;
  logic                    r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_din;
  logic [STRB_WIDTH-1:0]   r_ram_strb;

  logic                    w_setup;
  logic                    w_dec_err;

  // Only a genuine setup phase starts a transfer; psel with penable already
  // high while idle is a stray access phase and is ignored.
  assign w_setup = psel && !penable;

`ifdef APB_RAM_ADDR_CHECK_EN
  assign w_dec_err = (paddr[1:0] != 2'b00) ||
                     (paddr[ADDR_WIDTH-1:ADDR_WIDTH-2] != 2'b00);
`else
  assign w_dec_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_prdata     <= '0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_ram_enable <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_ram_strb   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (w_setup) begin
            r_ram_we   <= pwrite;
            r_ram_addr <= paddr;
            r_ram_din  <= pwdata;
            r_ram_strb <= pwrite ? pstrb : '0;
            r_cnt      <= '0;
            if (w_dec_err) begin
              r_state   <= ERR;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end else begin
              r_state      <= REQ;
              r_ram_enable <= 1'b1;
            end
          end
        end

        REQ: begin
          // An abandoned transfer drops the request. A write the RAM
          // accepted in this same cycle has already taken effect.
          if (!psel) begin
            r_state      <= IDLE;
            r_ram_enable <= 1'b0;
          end else if (ram_ready) begin
            r_state      <= CAPT;
            r_ram_enable <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= RESP;
            r_ram_enable <= 1'b0;
            r_pready     <= 1'b1;
            r_pslverr    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        CAPT: begin
          if (!psel) begin
            r_state <= IDLE;
          end else begin
            if (!r_ram_we) begin
              r_prdata <= ram_dout;
            end
            r_state   <= RESP;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b0;
          end
        end

        RESP, ERR: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end

        default: begin
          r_state      <= IDLE;
          r_pready     <= 1'b0;
          r_pslverr    <= 1'b0;
          r_ram_enable <= 1'b0;
        end
      endcase
    end
  end

  assign prdata     = r_prdata;
  assign pready     = r_pready;
  assign pslverr    = r_pslverr;
  assign ram_enable = r_ram_enable;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_strb   = r_ram_strb;

endmodule

// File: tb/tb_apb_ram_bridge.sv
// tb/tb_apb_ram_bridge.sv - self-checking bench for apb_ram_bridge

module tb_apb_ram_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic          ram_enable, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [3:0]    ram_strb;
  logic          ram_ready;
  logic [DW-1:0] ram_dout;

  apb_ram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .ram_enable(ram_enable),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_strb(ram_strb), .ram_ready(ram_ready), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic bit dec_err(input logic [15:0] a);
`ifdef APB_RAM_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a[15:14] != 2'b00);
`else
    return (a[0] & ~a[0]);
`endif
  endfunction

  // Environment RAM: accepts when enable && ready, registered read data,
  // random garbage on ram_dout in every other cycle.
  bit [31:0] ram_mem [0:16383];
  always @(posedge clk) begin
    if (ram_enable && ram_ready) begin
      if (ram_we) ram_mem[ram_addr[15:2]] <= merge(ram_mem[ram_addr[15:2]], ram_din, ram_strb);
      else        ram_dout <= ram_mem[ram_addr[15:2]];
    end else begin
      ram_dout <= $urandom;
    end
  end

  // Reference model state
  bit [31:0]  exp_mem [0:16383];
  logic       exp_pready, exp_pslverr, exp_ram_en;
  logic [31:0] exp_prdata;
  logic       cur_we;
  logic [15:0] cur_addr;
  logic [31:0] cur_din;
  logic [3:0] cur_strb;
  int         cur_j;
  int         obs_lat;
  logic       obs_err;
  bit         chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pready", pready, exp_pready);
      chk("pslverr", pslverr, exp_pslverr);
      chk("ram_enable", ram_enable, exp_ram_en);
      chk("prdata", prdata, exp_prdata);
      if (exp_ram_en) begin
        chk("ram_we", ram_we, cur_we);
        chk("ram_addr", ram_addr, cur_addr);
        chk("ram_din", ram_din, cur_din);
        chk("ram_strb", ram_strb, cur_we ? cur_strb : 4'h0);
      end
      if (pready === 1'b1 && cur_j > 0) begin
        obs_lat = cur_j;
        obs_err = pslverr;
      end
    end
  end

  task automatic go_idle();
    psel = 1'b0; penable = 1'b0; ram_ready = 1'b0; cur_j = 0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_ram_en = 1'b0;
  endtask

  // One APB transfer. Called just after a rising edge in a cycle where the
  // bridge is idle; returns just after the edge following pready. The RAM
  // answers after d not-ready access cycles. abort_at (>0) drops psel in
  // that access cycle.
  task automatic do_xfer(input bit we, input logic [15:0] a, input logic [31:0] dat,
                         input logic [3:0] st, input int d, input int abort_at);
    bit err;
    int last;
    err = dec_err(a);
    cur_we = we; cur_addr = a; cur_din = dat; cur_strb = st; cur_j = 0;
    psel = 1'b1; penable = 1'b0; pwrite = we; paddr = a; pwdata = dat; pstrb = st;
    ram_ready = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_ram_en = 1'b0;
    obs_lat = 0; obs_err = 1'b0;
    if (err)         last = 1;
    else if (d < TO) last = d + 3;
    else             last = TO + 1;
    for (int j = 1; j <= last; j++) begin
      @(posedge clk); #1;
      cur_j = j;
      ram_ready = (j > d);
      exp_ram_en = !err && (j <= d + 1) && (j <= TO);
      if (abort_at != 0 && j == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        exp_pready = 1'b0; exp_pslverr = 1'b0;
        @(posedge clk); #1;
        go_idle();
        return;
      end
      penable = 1'b1;
      exp_pready = (j == last);
      exp_pslverr = (j == last) && (err || d >= TO);
      if (j == last && !err && d < TO) begin
        if (we) exp_mem[a[15:2]] = merge(exp_mem[a[15:2]], dat, st);
        else    exp_prdata = exp_mem[a[15:2]];
      end
    end
    @(posedge clk); #1;
    go_idle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    cur_we = 1'b0; cur_addr = '0; cur_din = '0; cur_strb = '0;
    obs_lat = 0; obs_err = 1'b0;
    go_idle();
    exp_prdata = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ram_we", ram_we, 1'b0);
    chk("reset_ram_addr", ram_addr, 16'h0);
    chk("reset_ram_din", ram_din, 32'h0);
    chk("reset_ram_strb", ram_strb, 4'h0);
    @(posedge clk); #1;

    // Nominal write then read, 2 wait states each
    do_xfer(1'b1, 16'h1000, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("wr_latency", obs_lat, 3);
    chk("wr_pslverr", obs_err, 1'b0);
    idle_cycles(1);
    do_xfer(1'b0, 16'h1000, 32'h0, 4'hF, 0, 0);
    chk("rd_latency", obs_lat, 3);
    chk("rd_pslverr", obs_err, 1'b0);
    chk("rd_data_deadbeef", prdata, 32'hDEADBEEF);

    // Partial strobe write over a prior value
    do_xfer(1'b1, 16'h0040, 32'hAABBCCDD, 4'hF, 1, 0);
    do_xfer(1'b1, 16'h0040, 32'h11223344, 4'h3, 0, 0);
    do_xfer(1'b0, 16'h0040, 32'hFFFFFFFF, 4'hF, 2, 0);
    chk("strb_merge_data", prdata, 32'hAABB3344);
    chk("strb_rd_latency", obs_lat, 5);

    // RAM never ready: timeout error
    idle_cycles(2);
    do_xfer(1'b0, 16'h0200, 32'h0, 4'h0, TO, 0);
    chk("timeout_latency", obs_lat, TO + 1);
    chk("timeout_pslverr", obs_err, 1'b1);
    chk("timeout_prdata_kept", prdata, 32'hAABB3344);

    // Back-to-back write then read
    do_xfer(1'b1, 16'h0100, 32'hCAFEF00D, 4'hF, 0, 0);
    do_xfer(1'b0, 16'h0100, 32'h0, 4'h0, 0, 0);
    chk("b2b_rd_data", prdata, 32'hCAFEF00D);
    chk("b2b_rd_latency", obs_lat, 3);

`ifdef APB_RAM_ADDR_CHECK_EN
    do_xfer(1'b0, 16'h8000, 32'h0, 4'h0, 0, 0);
    chk("dec_hi_latency", obs_lat, 1);
    chk("dec_hi_pslverr", obs_err, 1'b1);
    do_xfer(1'b0, 16'h0042, 32'h0, 4'h0, 0, 0);
    chk("dec_lo_latency", obs_lat, 1);
    chk("dec_lo_pslverr", obs_err, 1'b1);
`endif

    // Abort: psel drops while waiting for the RAM
    do_xfer(1'b1, 16'h0100, 32'h12345678, 4'hF, 6, 3);
    chk("abort_no_pready", obs_lat, 0);
    idle_cycles(1);
    do_xfer(1'b0, 16'h0100, 32'h0, 4'h0, 0, 0);
    chk("abort_data_kept", prdata, 32'hCAFEF00D);

    // Stray access phase while idle is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; ram_ready = 1'b1;
    idle_cycles(3);
    go_idle();
    idle_cycles(1);

    // Reset during REQ
    do_xfer(1'b1, 16'h0300, 32'h55AA55AA, 4'hF, 10, 0) ;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0300; pstrb = 4'h0;
    cur_we = 1'b0; cur_addr = 16'h0300; cur_strb = 4'h0;
    @(posedge clk); #1;
    penable = 1'b1; exp_ram_en = 1'b1; cur_j = 1;
    @(posedge clk); #1;
    rst_n = 1'b0; cur_j = 2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    go_idle();
    exp_prdata = '0;
    @(negedge clk);
    chk("rst_mid_ram_we", ram_we, 1'b0);
    chk("rst_mid_ram_addr", ram_addr, 16'h0);
    chk("rst_mid_ram_din", ram_din, 32'h0);
    chk("rst_mid_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    do_xfer(1'b0, 16'h0300, 32'h0, 4'h0, 0, 0);
    chk("after_rst_latency", obs_lat, 3);
    chk("after_rst_data", prdata, 32'h55AA55AA);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      automatic bit          we  = 1'($urandom_range(0, 1));
      automatic logic [15:0] a   = 16'($urandom_range(0, 63)) << 2;
      automatic logic [31:0] dat = $urandom;
      automatic logic [3:0]  st  = 4'($urandom_range(0, 15));
      automatic int          r   = $urandom_range(0, 9);
      automatic int          d;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a[15:14] = 2'($urandom_range(1, 3));
      if (r < 6)      d = 0;
      else if (r < 9) d = $urandom_range(1, 5);
      else            d = $urandom_range(TO - 1, TO + 1);
      do_xfer(we, a, dat, st, d, 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_ram_bridge.md
APB_RAM_BRIDGE -- requirements
Module: apb_ram_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, APB/RAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, data width in bits; strobe width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles to wait for ram_ready before reporting an error.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 psel  in  1  APB select.
REQ-007 penable  in  1  APB access phase.
REQ-008 pwrite  in  1  APB direction; 1 = write.
REQ-009 paddr  in  ADDR_WIDTH  APB byte address.
REQ-010 pwdata  in  DATA_WIDTH  APB write data.
REQ-011 pstrb  in  DATA_WIDTH/8  APB byte strobes.
REQ-012 prdata  out  DATA_WIDTH  APB read data, registered.
REQ-013 pready  out  1  APB transfer complete, registered.
REQ-014 pslverr  out  1  APB error, valid only while pready=1.
REQ-015 ram_enable  out  1  RAM access request, registered.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-018 ram_din  out  DATA_WIDTH  RAM write data.
REQ-019 ram_strb  out  DATA_WIDTH/8  RAM byte strobes.
REQ-020 ram_ready  in  1  RAM accepts the request in the current cycle.
REQ-021 ram_dout  in  DATA_WIDTH  RAM read data; valid in the cycle after an accepted read.

Function
REQ-022 The FSM SHALL have the states IDLE, REQ, CAPT, RESP and ERR.
REQ-023 IDLE: on psel=1 and penable=0, the bridge SHALL latch paddr, pwrite, pwdata and pstrb, then go to ERR on a decode error, otherwise to REQ.
REQ-024 REQ: ram_enable=1 with the latched ram_we, ram_addr, ram_din and ram_strb; ram_strb SHALL be 0 for reads.
REQ-025 REQ: ram_ready=1 at an edge -> CAPT, and ram_enable is deasserted.
REQ-026 REQ: TIMEOUT consecutive cycles with ram_ready=0 -> RESP with pslverr=1 and ram_enable deasserted.
REQ-027 CAPT: at the edge, prdata <= ram_dout for reads; prdata is unchanged for writes; next state is RESP.
REQ-028 RESP: pready=1 for exactly one cycle, then IDLE.
REQ-029 ERR: pready=1 and pslverr=1 for one cycle, with no RAM access, then IDLE.
REQ-030 Nominal latency, with ram_ready=1 immediately: pready SHALL be high in the 3rd access-phase cycle (2 wait states) for both reads and writes.
REQ-031 pready and pslverr SHALL be 0 in all states other than RESP and ERR.
REQ-032 A back-to-back setup phase in the cycle after pready SHALL be accepted by IDLE with no extra bubble.
REQ-033 If psel drops before pready: the FSM SHALL return to IDLE at the next edge, without asserting pready.
REQ-034 In that case an already accepted RAM write SHALL NOT be retracted.
REQ-035 psel=1 with penable=1 while in IDLE (no setup phase) SHALL be ignored.

Reset
REQ-036 While rst_n=0 at an edge: the FSM SHALL go to IDLE and the timeout counter SHALL clear.
REQ-037 While rst_n=0 at an edge: prdata='0, pready=0, pslverr=0, ram_enable=0, ram_we=0, ram_addr='0, ram_din='0, ram_strb='0.
REQ-038 A reset asserted mid-transfer SHALL abort the transfer without asserting pready.

Configuration
REQ-039 Macro APB_RAM_ADDR_CHECK_EN defined: paddr[1:0]!=0 or paddr[ADDR_WIDTH-1:ADDR_WIDTH-2]!=0 SHALL be a decode error (ERR path).
REQ-040 Macro APB_RAM_ADDR_CHECK_EN undefined: no decode errors; every transfer SHALL be forwarded to the RAM.
REQ-041 The timeout error SHALL be reported with or without APB_RAM_ADDR_CHECK_EN.

Verification
REQ-042 Write 0x1000 data 0xDEADBEEF, pstrb=0xF, then read 0x1000 -> prdata=0xDEADBEEF, pslverr=0, and pready in the 3rd access cycle of each transfer.
REQ-043 Write 0x0040 data 0x11223344, pstrb=0x3 over prior 0xAABBCCDD -> read returns 0xAABB3344, and ram_strb=0 is observed during the read.
REQ-044 With APB_RAM_ADDR_CHECK_EN: read 0x8000, and separately read 0x0042 -> pready=1 and pslverr=1 in access cycle 1, with ram_enable never asserted.
REQ-045 ram_ready held 0 -> pready=1 and pslverr=1 after 16 REQ cycles, and ram_enable=0 afterwards.
REQ-046 Back-to-back write then read with no idle cycle -> both complete with correct data; reset during REQ -> all outputs 0 on the next cycle, FSM in IDLE.
